ex_stage_exmem: RTL and testbench

Execute stage plus EX/MEM pipeline register for the 5-stage MIPS pipeline. It consumes the ID/EX control and data fields and performs operand forwarding, the ALU operation and destination-register selection. The result is registered into EX/MEM for the memory stage. The registered EX/MEM outputs and the MEM/WB writeback bus are also the forwarding sources.

---
 rtl/ex_stage_exmem.sv | 152 +++++++++++++++
 tb/tb_ex_stage_exmem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_exmem.sv
// MIPS execute stage: operand forwarding, ALU and destination select, registered into EX/MEM.
// One cycle from ID/EX inputs to EX/MEM outputs; stall holds EX/MEM and flush loads a control bubble.
module ex_stage_exmem #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_write,
    input  logic [1:0]        reg_dst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] sgn_ext,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] adder1,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              reg_write_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [1:0]        mem_to_reg_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic [REG_W-1:0]  dest_reg_out,
    output logic [DATA_W-1:0] adder1_out,
    output logic              zero_out
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [1:0]        mem_to_reg;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  dest_reg;
        logic [DATA_W-1:0] adder1;
        logic              zero;
    } exmem_t;

    exmem_t exmem_q, exmem_d, bubble_d;

    logic [DATA_W-1:0] fwd_exmem;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [REG_W-1:0]  dest_sel;
    logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

    // A jal sitting in EX/MEM forwards its link address rather than the ALU result.
    assign fwd_exmem = (exmem_q.mem_to_reg == 2'b10) ? exmem_q.adder1 : exmem_q.alu_result;

    assign ex_hit_a = exmem_q.reg_write && (exmem_q.dest_reg != '0) && (exmem_q.dest_reg == rs);
    assign ex_hit_b = exmem_q.reg_write && (exmem_q.dest_reg != '0) && (exmem_q.dest_reg == rt);
    assign wb_hit_a = wb_reg_write && (wb_rd != '0) && (wb_rd == rs);
    assign wb_hit_b = wb_reg_write && (wb_rd != '0) && (wb_rd == rt);

    always_comb begin
        fwd_a = read_data1;
        if (ex_hit_a) begin
            fwd_a = fwd_exmem;
        end else if (wb_hit_a) begin
            fwd_a = wb_data;
        end
        fwd_b = read_data2;
        if (ex_hit_b) begin
            fwd_b = fwd_exmem;
        end else if (wb_hit_b) begin
            fwd_b = wb_data;
        end
    end

    assign alu_b = alu_src ? sgn_ext : fwd_b;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000:  alu_res = fwd_a + alu_b;
            3'b001:  alu_res = fwd_a - alu_b;
            3'b010:  alu_res = fwd_a & alu_b;
            3'b011:  alu_res = fwd_a | alu_b;
            3'b100:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
            3'b101:  alu_res = ~(fwd_a | alu_b);
            3'b110:  alu_res = alu_b << 16;
            default: alu_res = fwd_a;
        endcase
    end

    always_comb begin
        dest_sel = '0;
        case (reg_dst)
            2'b00:   dest_sel = rt;
            2'b01:   dest_sel = rd;
            2'b10:   dest_sel = REG_W'(31);
            default: dest_sel = '0;
        endcase
    end

    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = reg_write;
        exmem_d.mem_read   = mem_read;
        exmem_d.mem_write  = mem_write;
        exmem_d.mem_to_reg = mem_to_reg;
        exmem_d.alu_result = alu_res;
        exmem_d.write_data = fwd_b;
        exmem_d.dest_reg   = dest_sel;
        exmem_d.adder1     = adder1;
        exmem_d.zero       = (alu_res == '0);
    end

    // Bubble keeps the data fields so only the side-effecting controls are killed.
    always_comb begin
        bubble_d            = exmem_d;
        bubble_d.reg_write  = 1'b0;
        bubble_d.mem_read   = 1'b0;
        bubble_d.mem_write  = 1'b0;
        bubble_d.mem_to_reg = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_q <= '0;
        end else if (flush) begin
            exmem_q <= bubble_d;
        end else if (!stall) begin
            exmem_q <= exmem_d;
        end
    end

    assign reg_write_out  = exmem_q.reg_write;
    assign mem_read_out   = exmem_q.mem_read;
    assign mem_write_out  = exmem_q.mem_write;
    assign mem_to_reg_out = exmem_q.mem_to_reg;
    assign alu_result_out = exmem_q.alu_result;
    assign write_data_out = exmem_q.write_data;
    assign dest_reg_out   = exmem_q.dest_reg;
    assign adder1_out     = exmem_q.adder1;
    assign zero_out       = exmem_q.zero;

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Bench for ex_stage_exmem: directed vector table, stall/flush sequence, then random traffic vs a reference model.
module tb_ex_stage_exmem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush;
    logic [2:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, wb_reg_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [31:0] read_data1, read_data2, sgn_ext, adder1, wb_data;
    logic [4:0]  rs, rt, rd, wb_rd;

    logic        reg_write_out, mem_read_out, mem_write_out, zero_out;
    logic [1:0]  mem_to_reg_out;
    logic [31:0] alu_result_out, write_data_out, adder1_out;
    logic [4:0]  dest_reg_out;

    ex_stage_exmem #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .read_data1(read_data1), .read_data2(read_data2), .sgn_ext(sgn_ext),
        .rs(rs), .rt(rt), .rd(rd), .adder1(adder1),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .alu_result_out(alu_result_out), .write_data_out(write_data_out),
        .dest_reg_out(dest_reg_out), .adder1_out(adder1_out), .zero_out(zero_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the architectural content of the EX/MEM latch.
    typedef struct {
        logic        rw, mr, mw, zero;
        logic [1:0]  m2r;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  dest;
    } mdl_t;
    mdl_t m;

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (m.rw && m.dest != 0 && m.dest == idx) return (m.m2r == 2'b10) ? m.pc4 : m.alu;
        if (wb_reg_write && wb_rd != 0 && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic mdl_t model_next();
        mdl_t n;
        logic [31:0] a, b, opb, r;
        a = operand(rs, read_data1);
        b = operand(rt, read_data2);
        opb = alu_src ? sgn_ext : b;
        case (alu_op)
            3'd0: r = a + opb;
            3'd1: r = a - opb;
            3'd2: r = a & opb;
            3'd3: r = a | opb;
            3'd4: r = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            3'd5: r = ~(a | opb);
            3'd6: r = opb * 32'd65536;
            default: r = a;
        endcase
        n.rw = reg_write; n.mr = mem_read; n.mw = mem_write; n.m2r = mem_to_reg;
        n.alu = r; n.wd = b; n.pc4 = adder1; n.zero = (r == 0);
        n.dest = (reg_dst == 2'd0) ? rt : (reg_dst == 2'd1) ? rd : (reg_dst == 2'd2) ? 5'd31 : 5'd0;
        if (rst) begin
            n = '{default: '0};
        end else if (flush) begin
            n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
        end else if (stall) begin
            n = m;
        end
        return n;
    endfunction

    task automatic tick();
        mdl_t nx;
        nx = model_next();
        @(posedge clk);
        #1;
        m = nx;
    endtask

    function automatic logic [127:0] dut_vec();
        return {21'd0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, alu_result_out,
                write_data_out, dest_reg_out, adder1_out, zero_out};
    endfunction

    function automatic logic [127:0] mdl_vec();
        return {21'd0, m.rw, m.mr, m.mw, m.m2r, m.alu, m.wd, m.dest, m.pc4, m.zero};
    endfunction

    function automatic logic [4:0] pick_idx();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    task automatic rand_inputs();
        alu_op = 3'($urandom); alu_src = 1'($urandom); reg_write = 1'($urandom);
        reg_dst = 2'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_to_reg = 2'($urandom); read_data1 = $urandom; read_data2 = $urandom;
        sgn_ext = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        rs = pick_idx(); rt = pick_idx(); rd = pick_idx(); adder1 = $urandom;
        wb_reg_write = 1'($urandom); wb_rd = pick_idx(); wb_data = $urandom;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        src, rw;
        logic [1:0]  rdst, m2r;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc4;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdat;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [31:0] e_wd;
        logic [4:0]  e_dest;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic src, input logic rw,
                                input logic [1:0] rdst, input logic [1:0] m2r,
                                input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [4:0] vrs, input logic [4:0] vrt, input logic [4:0] vrd,
                                input logic [31:0] pc4, input logic wbwe, input logic [4:0] wbrd,
                                input logic [31:0] wbdat, input logic [31:0] e_alu, input logic e_zero,
                                input logic [31:0] e_wd, input logic [4:0] e_dest);
        vec_t v;
        v.op = op; v.src = src; v.rw = rw; v.rdst = rdst; v.m2r = m2r;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rs = vrs; v.rt = vrt; v.rd = vrd;
        v.pc4 = pc4; v.wbwe = wbwe; v.wbrd = wbrd; v.wbdat = wbdat;
        v.e_alu = e_alu; v.e_zero = e_zero; v.e_wd = e_wd; v.e_dest = e_dest;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        m = '{default: '0};
        // op src rw rdst m2r rd1 rd2 imm rs rt rd pc4 wbwe wbrd wbdat | alu zero wdata dest
        vecs[0]  = mk(3'd0, 0, 0, 2'd1, 2'd0, 32'd7, 32'd9, 32'd0, 1, 2, 4, 32'h4, 0, 0, 0, 32'd16, 0, 32'd9, 5'd4);
        vecs[1]  = mk(3'd1, 0, 0, 2'd1, 2'd0, 32'd7, 32'd9, 32'd0, 1, 2, 4, 32'h4, 0, 0, 0, 32'hFFFFFFFE, 0, 32'd9, 5'd4);
        vecs[2]  = mk(3'd4, 0, 0, 2'd1, 2'd0, 32'd7, 32'd9, 32'd0, 1, 2, 4, 32'h4, 0, 0, 0, 32'd1, 0, 32'd9, 5'd4);
        vecs[3]  = mk(3'd1, 0, 0, 2'd1, 2'd0, 32'd9, 32'd9, 32'd0, 1, 2, 4, 32'h4, 0, 0, 0, 32'd0, 1, 32'd9, 5'd4);
        vecs[4]  = mk(3'd0, 0, 1, 2'd1, 2'd0, 32'h8, 32'h8, 32'd0, 1, 2, 8, 32'h8, 0, 0, 0, 32'h10, 0, 32'h8, 5'd8);
        vecs[5]  = mk(3'd7, 0, 1, 2'd1, 2'd0, 32'h0, 32'h0, 32'd0, 8, 2, 8, 32'h8, 0, 0, 0, 32'h10, 0, 32'h0, 5'd8);
        vecs[6]  = mk(3'd7, 0, 0, 2'd1, 2'd0, 32'h0, 32'h0, 32'd0, 8, 2, 0, 32'h8, 1, 8, 32'h55, 32'h10, 0, 32'h0, 5'd0);
        vecs[7]  = mk(3'd3, 0, 0, 2'd0, 2'd0, 32'h0, 32'h11, 32'd0, 1, 3, 0, 32'h8, 1, 3, 32'hAB, 32'hAB, 0, 32'hAB, 5'd3);
        vecs[8]  = mk(3'd3, 0, 0, 2'd0, 2'd0, 32'h0, 32'h22, 32'd0, 0, 0, 0, 32'h8, 1, 0, 32'hAB, 32'h22, 0, 32'h22, 5'd0);
        vecs[9]  = mk(3'd0, 0, 1, 2'd0, 2'd0, 32'h5, 32'h6, 32'd0, 1, 0, 0, 32'h8, 0, 0, 0, 32'hB, 0, 32'h6, 5'd0);
        vecs[10] = mk(3'd7, 0, 0, 2'd0, 2'd0, 32'h33, 32'h44, 32'd0, 0, 0, 0, 32'h8, 0, 0, 0, 32'h33, 0, 32'h44, 5'd0);
        vecs[11] = mk(3'd0, 0, 1, 2'd2, 2'd2, 32'h1, 32'h2, 32'd0, 5, 6, 0, 32'h404, 0, 0, 0, 32'h3, 0, 32'h2, 5'd31);
        vecs[12] = mk(3'd7, 0, 0, 2'd0, 2'd0, 32'h0, 32'h0, 32'd0, 31, 6, 0, 32'h408, 0, 0, 0, 32'h404, 0, 32'h0, 5'd6);
        vecs[13] = mk(3'd6, 1, 0, 2'd0, 2'd0, 32'h0, 32'h7, 32'h1234, 1, 2, 0, 32'h8, 0, 0, 0, 32'h12340000, 0, 32'h7, 5'd2);
        vecs[14] = mk(3'd5, 0, 0, 2'd0, 2'd0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'd0, 1, 2, 0, 32'h8, 0, 0, 0, 32'h0000000F, 0, 32'h0F0F0F00, 5'd2);
        vecs[15] = mk(3'd2, 1, 0, 2'd0, 2'd0, 32'hFF00FF00, 32'h1, 32'h0FF00FF0, 1, 2, 0, 32'h8, 0, 0, 0, 32'h0F000F00, 0, 32'h1, 5'd2);
        vecs[16] = mk(3'd4, 0, 0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h1, 32'd0, 1, 2, 0, 32'h8, 0, 0, 0, 32'd1, 0, 32'h1, 5'd2);
        vecs[17] = mk(3'd4, 0, 0, 2'd3, 2'd0, 32'h1, 32'hFFFFFFFF, 32'd0, 1, 2, 9, 32'h8, 0, 0, 0, 32'd0, 1, 32'hFFFFFFFF, 5'd0);

        // Reset with random inputs, then release under stall.
        stall = 0; flush = 0; rst = 1;
        rand_inputs();
        tick();
        chk("reset_cycle1", dut_vec(), 128'd0);
        rand_inputs();
        tick();
        chk("reset_cycle2", dut_vec(), 128'd0);
        rst = 0; stall = 1;
        rand_inputs();
        tick();
        chk("reset_release_stall", dut_vec(), 128'd0);
        stall = 0;

        mem_read = 0; mem_write = 0;
        for (int i = 0; i < 18; i++) begin
            alu_op = vecs[i].op; alu_src = vecs[i].src; reg_write = vecs[i].rw;
            reg_dst = vecs[i].rdst; mem_to_reg = vecs[i].m2r;
            read_data1 = vecs[i].rd1; read_data2 = vecs[i].rd2; sgn_ext = vecs[i].imm;
            rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; adder1 = vecs[i].pc4;
            wb_reg_write = vecs[i].wbwe; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbdat;
            tick();
            chk($sformatf("vec%0d_alu", i), 128'(alu_result_out), 128'(vecs[i].e_alu));
            chk($sformatf("vec%0d_zero", i), 128'(zero_out), 128'(vecs[i].e_zero));
            chk($sformatf("vec%0d_wdata", i), 128'(write_data_out), 128'(vecs[i].e_wd));
            chk($sformatf("vec%0d_dest", i), 128'(dest_reg_out), 128'(vecs[i].e_dest));
        end

        // Store/load instruction, held for three stalled cycles, then flush+stall kills its controls.
        alu_op = 3'd0; alu_src = 0; reg_write = 1; reg_dst = 2'd1; mem_read = 1; mem_write = 1;
        mem_to_reg = 2'd1; read_data1 = 32'h100; read_data2 = 32'h23; sgn_ext = 0;
        rs = 1; rt = 2; rd = 7; adder1 = 32'h40; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
        tick();
        chk("ldst_alu", 128'(alu_result_out), 128'h123);
        chk("ldst_ctrl", 128'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}), 128'b11101);
        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            stall = 1;
            tick();
            chk($sformatf("stall%0d_alu", c), 128'(alu_result_out), 128'h123);
            chk($sformatf("stall%0d_ctrl", c),
                128'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, dest_reg_out}), 128'({5'b11101, 5'd7}));
        end
        alu_op = 3'd0; alu_src = 0; reg_write = 1; reg_dst = 2'd1; mem_read = 1; mem_write = 1;
        mem_to_reg = 2'd1; read_data1 = 32'h200; read_data2 = 32'h1; rs = 1; rt = 2; rd = 9;
        wb_reg_write = 0; stall = 1; flush = 1;
        tick();
        chk("flush_alu", 128'(alu_result_out), 128'h201);
        chk("flush_wdata", 128'(write_data_out), 128'h1);
        chk("flush_ctrl", 128'({reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out}), 128'd0);
        chk("flush_model", dut_vec(), mdl_vec());
        stall = 0; flush = 0;

        // Random traffic with occasional stall, flush and reset.
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            tick();
            chk($sformatf("rand%0d", c), dut_vec(), mdl_vec());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
